// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweeper and related stimulus engines.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_e;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Expected truth table of a 4-input XOR, vector k -> bit k.
    localparam logic [15:0] XOR4_TABLE = 16'h6996;

endpackage

// File: rtl/settle_counter.sv
// Loadable down-counter with a zero flag; counts settle cycles between stimulus and sampling.
module settle_counter #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_c_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority; decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c_o = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks all input vectors, waits a settle time, checks a 1-bit
// function output against a latched truth table and reports pass/fail statistics.
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = N_IN + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop_on_fail,
    input  logic [(1<<N_IN)-1:0]    exp_table,
    input  logic                    func_o,
    output logic [N_IN-1:0]         vec,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [CNT_W-1:0]        mismatch_cnt,
    output logic [N_IN-1:0]         first_fail,
    output logic                    fail_seen
);

    localparam int unsigned NUM_VEC = 1 << N_IN;
    localparam int unsigned SC_W    = clog2(SETTLE) + 1;

    localparam logic [SC_W-1:0]  SETTLE_LOAD = SC_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  VEC_LAST    = N_IN'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(NUM_VEC);

    state_e               state_q, state_d;
    logic [N_IN-1:0]      vec_q, vec_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_IN-1:0]      first_q, first_d;
    logic                 fail_q, fail_d;
    logic [NUM_VEC-1:0]   tbl_q, tbl_d;
    logic                 sof_q, sof_d;

    logic                 sc_load_c;
    logic                 sc_dec_c;
    logic                 sc_zero_c;
    logic                 mism_c;

    settle_counter #(
        .W (SC_W)
    ) u_settle (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (sc_load_c),
        .load_val_i (SETTLE_LOAD),
        .dec_i      (sc_dec_c),
        .zero_c_o   (sc_zero_c)
    );

    // Function output is only meaningful in SAMPLE; elsewhere this is ignored.
    assign mism_c = (func_o != tbl_q[vec_q]);

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        fail_d    = fail_q;
        tbl_d     = tbl_q;
        sof_d     = sof_q;
        sc_load_c = 1'b0;
        sc_dec_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    tbl_d     = exp_table;
                    sof_d     = stop_on_fail;
                    vec_d     = '0;
                    cnt_d     = '0;
                    first_d   = '0;
                    fail_d    = 1'b0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    sc_load_c = 1'b1;
                    state_d   = APPLY;
                end
            end

            APPLY: begin
                if (sc_zero_c) begin
                    state_d = SAMPLE;
                end else begin
                    sc_dec_c = 1'b1;
                end
            end

            SAMPLE: begin
                if (mism_c) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (!fail_q) begin
                        first_d = vec_q;
                    end
                    fail_d = 1'b1;
                end
                if ((vec_q == VEC_LAST) || (mism_c && sof_q)) begin
                    done_d  = 1'b1;
                    pass_d  = (cnt_d == '0);
                    state_d = FINISH;
                end else begin
                    vec_d     = vec_q + N_IN'(1);
                    sc_load_c = 1'b1;
                    state_d   = APPLY;
                end
            end

            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            cnt_q   <= '0;
            first_q <= '0;
            fail_q  <= 1'b0;
            tbl_q   <= '0;
            sof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            fail_q  <= fail_d;
            tbl_q   <= tbl_d;
            sof_q   <= sof_d;
        end
    end

    assign vec          = vec_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign mismatch_cnt = cnt_q;
    assign first_fail   = first_q;
    assign fail_seen    = fail_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: SETTLE=1 and SETTLE=3 instances on 4 inputs.
module tb_truth_table_sweeper;
    import tt_pkg::*;

    typedef struct {
        logic p;
        int   cnt;
        int   first;
        logic fs;
        int   vec;
        int   lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start1 = 1'b0, sof1 = 1'b0, func1;
    logic [15:0] tbl1 = '0;
    logic [3:0]  vec1, ff1;
    logic        busy1, done1, pass1, fs1;
    logic [4:0]  cnt1;

    logic        start3 = 1'b0, sof3 = 1'b0, func3;
    logic [15:0] tbl3 = '0;
    logic [3:0]  vec3, ff3;
    logic        busy3, done3, pass3, fs3;
    logic [4:0]  cnt3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sc1 = 0, sc3 = 0;
    int mode1 = 0, mode3 = 0;
    int age1 = 1000, age3 = 1000;
    logic [3:0] last1 = '0, last3 = '0;
    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    truth_table_sweeper #(.N_IN(4), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .stop_on_fail(sof1), .exp_table(tbl1),
        .func_o(func1), .vec(vec1), .busy(busy1), .done(done1), .pass(pass1),
        .mismatch_cnt(cnt1), .first_fail(ff1), .fail_seen(fs1)
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .stop_on_fail(sof3), .exp_table(tbl3),
        .func_o(func3), .vec(vec3), .busy(busy3), .done(done3), .pass(pass3),
        .mismatch_cnt(cnt3), .first_fail(ff3), .fail_seen(fs3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Track how many cycles each vector has been presented (observed on falling edges).
    always @(negedge clk) begin
        if (vec1 != last1) begin
            last1 <= vec1;
            age1  <= 1;
        end else if (age1 < 1000) begin
            age1 <= age1 + 1;
        end
        if (vec3 != last3) begin
            last3 <= vec3;
            age3  <= 1;
        end else if (age3 < 1000) begin
            age3 <= age3 + 1;
        end
    end

    // Function models: 0 = XOR, 1 = stuck at 0, 2 = XOR correct only from the 3rd cycle of a vector.
    always_comb begin
        case (mode1)
            0:       func1 = ^vec1;
            1:       func1 = 1'b0;
            default: func1 = (age1 >= 3) ? ^vec1 : ~^vec1;
        endcase
        case (mode3)
            0:       func3 = ^vec3;
            1:       func3 = 1'b0;
            default: func3 = (age3 >= 3) ? ^vec3 : ~^vec3;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks = checks + 1;
        if (act !== expv) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Monitor: pop and compare whenever a sweep reports done.
    always @(negedge clk) begin
        if (rst_n && done1) begin
            if (q1.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL dut1_unexpected_done: got done=1 expected no pending sweep");
            end else begin
                e1 = q1.pop_front();
                chk("dut1_pass", 32'(pass1), 32'(e1.p));
                chk("dut1_mismatch_cnt", 32'(cnt1), e1.cnt);
                chk("dut1_first_fail", 32'(ff1), e1.first);
                chk("dut1_fail_seen", 32'(fs1), 32'(e1.fs));
                chk("dut1_last_vec", 32'(vec1), e1.vec);
                chk("dut1_latency", cyc - sc1, e1.lat);
            end
        end
        if (rst_n && done3) begin
            if (q3.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL dut3_unexpected_done: got done=1 expected no pending sweep");
            end else begin
                e3 = q3.pop_front();
                chk("dut3_pass", 32'(pass3), 32'(e3.p));
                chk("dut3_mismatch_cnt", 32'(cnt3), e3.cnt);
                chk("dut3_first_fail", 32'(ff3), e3.first);
                chk("dut3_fail_seen", 32'(fs3), 32'(e3.fs));
                chk("dut3_last_vec", 32'(vec3), e3.vec);
                chk("dut3_latency", cyc - sc3, e3.lat);
            end
        end
    end

    task automatic issue1(input logic [15:0] tbl, input logic sof, input bit push, input exp_t e);
        @(negedge clk);
        tbl1   = tbl;
        sof1   = sof;
        start1 = 1'b1;
        sc1    = cyc;
        if (push) q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic issue3(input logic [15:0] tbl, input logic sof, input exp_t e);
        @(negedge clk);
        tbl3   = tbl;
        sof3   = sof;
        start3 = 1'b1;
        sc3    = cyc;
        q3.push_back(e);
        @(negedge clk);
        start3 = 1'b0;
    endtask

    // Wait (bounded) for done; optionally pulse start in the done cycle, which must be ignored.
    task automatic wait_done1(input bit poke);
        bit seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL dut1_done_timeout: got no done expected done within 400 cycles");
        end
        if (poke) start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("dut1_done_one_cycle", 32'(done1), 32'd0);
        chk("dut1_busy_after_done", 32'(busy1), 32'd0);
        @(negedge clk);
        chk("dut1_busy_idle", 32'(busy1), 32'd0);
    endtask

    task automatic wait_done3();
        bit seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done3) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL dut3_done_timeout: got no done expected done within 400 cycles");
        end
        @(negedge clk);
        chk("dut3_done_one_cycle", 32'(done3), 32'd0);
        chk("dut3_busy_after_done", 32'(busy3), 32'd0);
    endtask

    initial begin
        bit found;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_vec", 32'(vec1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_pass", 32'(pass1), 32'd0);
        chk("rst_cnt", 32'(cnt1), 32'd0);
        chk("rst_first", 32'(ff1), 32'd0);
        chk("rst_fail_seen", 32'(fs1), 32'd0);
        chk("rst_busy3", 32'(busy3), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // XOR against its own table: vec steps every 2 cycles; table/mode changes mid-sweep ignored.
        mode1 = 0;
        issue1(XOR4_TABLE, 1'b0, 1'b1, '{1'b1, 0, 0, 1'b0, 15, 33});
        for (int t = 1; t <= 32; t++) begin
            chk("xor_vec_step", 32'(vec1), (t - 1) / 2);
            chk("xor_busy", 32'(busy1), 32'd1);
            if (t == 10) begin
                tbl1 = 16'h0000;
                sof1 = 1'b1;
            end
            @(negedge clk);
        end
        wait_done1(1'b1);

        // One wrong table bit at vector 0; a start pulse while busy must be ignored.
        issue1(16'h6997, 1'b0, 1'b1, '{1'b0, 1, 0, 1'b1, 15, 33});
        repeat (5) @(negedge clk);
        start1 = 1'b1;
        tbl1   = 16'h0000;
        @(negedge clk);
        start1 = 1'b0;
        wait_done1(1'b0);

        // Stuck-at-0 with stop_on_fail: stops at vector 1.
        mode1 = 1;
        issue1(XOR4_TABLE, 1'b1, 1'b1, '{1'b0, 1, 1, 1'b1, 1, 5});
        wait_done1(1'b0);

        // Stuck-at-0 full sweep, twice; the second start clears the statistics.
        issue1(XOR4_TABLE, 1'b0, 1'b1, '{1'b0, 8, 1, 1'b1, 15, 33});
        wait_done1(1'b0);
        issue1(XOR4_TABLE, 1'b0, 1'b1, '{1'b0, 8, 1, 1'b1, 15, 33});
        chk("restart_cnt_clear", 32'(cnt1), 32'd0);
        chk("restart_fail_clear", 32'(fs1), 32'd0);
        chk("restart_first_clear", 32'(ff1), 32'd0);
        chk("restart_busy", 32'(busy1), 32'd1);
        wait_done1(1'b0);

        // Slow function: SETTLE=3 waits long enough.
        mode3 = 2;
        issue3(XOR4_TABLE, 1'b0, '{1'b1, 0, 0, 1'b0, 15, 65});
        wait_done3();

        // Same slow function with SETTLE=1: every vector is sampled too early; count saturates at 16.
        mode1 = 2;
        issue1(XOR4_TABLE, 1'b0, 1'b1, '{1'b0, 16, 0, 1'b1, 15, 33});
        wait_done1(1'b0);

        // Reset mid-sweep at vector 7: immediate clear, no done.
        mode1 = 0;
        issue1(XOR4_TABLE, 1'b0, 1'b0, '{1'b1, 0, 0, 1'b0, 15, 33});
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (vec1 == 4'd7) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("abort_reached_vec7", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_vec", 32'(vec1), 32'd0);
        chk("abort_busy", 32'(busy1), 32'd0);
        chk("abort_done", 32'(done1), 32'd0);
        chk("abort_pass", 32'(pass1), 32'd0);
        chk("abort_cnt", 32'(cnt1), 32'd0);
        chk("abort_fail_seen", 32'(fs1), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done1), 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_idle_busy", 32'(busy1), 32'd0);
        issue1(XOR4_TABLE, 1'b0, 1'b1, '{1'b1, 0, 0, 1'b0, 15, 33});
        wait_done1(1'b0);

        chk("q1_drained", q1.size(), 32'd0);
        chk("q3_drained", q3.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected normal completion");
        $fatal(1, "watchdog expired");
    end

endmodule
